spmv_mc_port: RTL and testbench

//  Adapter between one spmv_pe memory port and one Convey memory-controller (MC) port.

---
 rtl/spmv_mc_port.sv | 174 +++++++++++++++++
 tb/tb_spmv_mc_port.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mc_port.sv
// rtl/spmv_mc_port.sv - spmv_pe memory port to Convey MC port adapter with load credits
module spmv_mc_port #(
  parameter int REQ_DEPTH   = 32,
  parameter int RSP_DEPTH   = 32,
  parameter int STALL_SLACK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_ld,
  input  logic        req_mem_st,
  input  logic [47:0] req_mem_addr,
  input  logic [63:0] req_mem_d_or_tag,
  output logic        req_mem_stall,
  output logic        rsp_mem_push,
  output logic [2:0]  rsp_mem_tag,
  output logic [63:0] rsp_mem_q,
  input  logic        rsp_mem_stall,
  output logic        mc_req_ld,
  output logic        mc_req_st,
  output logic [47:0] mc_req_vadr,
  output logic [63:0] mc_req_wrd_rdctl,
  input  logic        mc_req_stall,
  input  logic        mc_rsp_push,
  input  logic [31:0] mc_rsp_rdctl,
  input  logic [63:0] mc_rsp_data,
  output logic        mc_rsp_stall,
  output logic        busy,
  output logic        err_overflow
);

  localparam int QA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam int QW = 64 + 48 + 2;
  localparam int SW = 3 + 64;
  localparam logic [QA:0] REQ_FULL  = (QA+1)'(REQ_DEPTH);
  localparam logic [QA:0] REQ_SLACK = (QA+1)'(STALL_SLACK);
  localparam logic [SA:0] RSP_FULL  = (SA+1)'(RSP_DEPTH);

  // Storage arrays carry no reset; only the pointers and counts define contents.
  logic [QW-1:0] req_ram [REQ_DEPTH];
  logic [SW-1:0] rsp_ram [RSP_DEPTH];

  logic [QA-1:0] req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [QA:0]   req_cnt_q, req_cnt_d;
  logic [SA-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic [SA:0]   rsp_cnt_q, rsp_cnt_d;
  logic [SA:0]   out_q, out_d;
  logic          req_stall_q, req_stall_d;
  logic          err_q, err_d;
  logic          rsp_push_q, rsp_push_d;
  logic [2:0]    rsp_tag_q, rsp_tag_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic          req_push, req_full, req_empty, req_wr;
  logic          rsp_full, rsp_empty, rsp_wr, rsp_rd;
  logic          fire, ld_fire;
  logic [QW-1:0] head;
  logic [SW-1:0] rsp_head;
  logic          head_ld, head_st;
  logic [47:0]   head_addr;
  logic [63:0]   head_dt;
  logic          unused_rdctl;

  assign unused_rdctl = ^mc_rsp_rdctl[31:3];

  // Next-state logic: FIFO bookkeeping, issue decision, credit accounting, response staging.
  always_comb begin
    req_push  = req_mem_ld | req_mem_st;
    req_full  = (req_cnt_q == REQ_FULL);
    req_empty = (req_cnt_q == '0);
    req_wr    = req_push && !req_full;

    head      = req_ram[req_rp_q];
    head_ld   = head[0];
    head_st   = head[1];
    head_addr = head[49:2];
    head_dt   = head[113:50];

    // A load at the head waits for a credit and holds back everything behind it.
    fire      = !req_empty && !mc_req_stall && (head_st || (out_q < RSP_FULL));
    ld_fire   = fire && head_ld;

    rsp_full  = (rsp_cnt_q == RSP_FULL);
    rsp_empty = (rsp_cnt_q == '0);
    rsp_wr    = mc_rsp_push && !rsp_full;
    rsp_rd    = !rsp_empty && !rsp_mem_stall;
    rsp_head  = rsp_ram[rsp_rp_q];

    req_wp_d  = req_wr ? req_wp_q + QA'(1) : req_wp_q;
    req_rp_d  = fire   ? req_rp_q + QA'(1) : req_rp_q;
    case ({req_wr, fire})
      2'b10:   req_cnt_d = req_cnt_q + (QA+1)'(1);
      2'b01:   req_cnt_d = req_cnt_q - (QA+1)'(1);
      default: req_cnt_d = req_cnt_q;
    endcase
    // Registered stall, early enough that the PE's in-flight requests still fit.
    req_stall_d = ((REQ_FULL - req_cnt_q) <= REQ_SLACK);

    rsp_wp_d  = rsp_wr ? rsp_wp_q + SA'(1) : rsp_wp_q;
    rsp_rp_d  = rsp_rd ? rsp_rp_q + SA'(1) : rsp_rp_q;
    case ({rsp_wr, rsp_rd})
      2'b10:   rsp_cnt_d = rsp_cnt_q + (SA+1)'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - (SA+1)'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase

    // A credit is held from load issue until its data leaves towards the PE.
    case ({ld_fire, rsp_rd})
      2'b10:   out_d = out_q + (SA+1)'(1);
      2'b01:   out_d = out_q - (SA+1)'(1);
      default: out_d = out_q;
    endcase

    err_d = err_q | (req_push && req_full) | (mc_rsp_push && (out_q == '0));

    rsp_push_d = rsp_rd;
    rsp_tag_d  = rsp_rd ? rsp_head[66:64] : rsp_tag_q;
    rsp_data_d = rsp_rd ? rsp_head[63:0]  : rsp_data_q;
  end

  // Control state: pointers, counts, credits, sticky error and registered PE-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wp_q    <= '0;
      req_rp_q    <= '0;
      req_cnt_q   <= '0;
      rsp_wp_q    <= '0;
      rsp_rp_q    <= '0;
      rsp_cnt_q   <= '0;
      out_q       <= '0;
      req_stall_q <= 1'b0;
      err_q       <= 1'b0;
      rsp_push_q  <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      req_wp_q    <= req_wp_d;
      req_rp_q    <= req_rp_d;
      req_cnt_q   <= req_cnt_d;
      rsp_wp_q    <= rsp_wp_d;
      rsp_rp_q    <= rsp_rp_d;
      rsp_cnt_q   <= rsp_cnt_d;
      out_q       <= out_d;
      req_stall_q <= req_stall_d;
      err_q       <= err_d;
      rsp_push_q  <= rsp_push_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Request storage write port.
  always_ff @(posedge clk) begin
    if (req_wr) req_ram[req_wp_q] <= {req_mem_d_or_tag, req_mem_addr, req_mem_st, req_mem_ld};
  end

  // Response storage write port.
  always_ff @(posedge clk) begin
    if (rsp_wr) rsp_ram[rsp_wp_q] <= {mc_rsp_rdctl[2:0], mc_rsp_data};
  end

  assign req_mem_stall    = req_stall_q;
  assign rsp_mem_push     = rsp_push_q;
  assign rsp_mem_tag      = rsp_tag_q;
  assign rsp_mem_q        = rsp_data_q;
  assign mc_req_ld        = ld_fire;
  assign mc_req_st        = fire && head_st;
  assign mc_req_vadr      = fire ? head_addr : '0;
  assign mc_req_wrd_rdctl = !fire ? '0 : (head_st ? head_dt : {61'b0, head_dt[2:0]});
  assign mc_rsp_stall     = 1'b0;
  assign busy             = !req_empty || (out_q != '0) || !rsp_empty;
  assign err_overflow     = err_q;

endmodule

// File: tb/tb_spmv_mc_port.sv
// tb/tb_spmv_mc_port.sv - scoreboard bench for spmv_mc_port
module tb_spmv_mc_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_mem_ld = 1'b0, req_mem_st = 1'b0;
  logic [47:0] req_mem_addr = '0;
  logic [63:0] req_mem_d_or_tag = '0;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall = 1'b0;
  logic        mc_req_ld, mc_req_st;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic        mc_req_stall = 1'b0;
  logic        mc_rsp_push = 1'b0;
  logic [31:0] mc_rsp_rdctl = '0;
  logic [63:0] mc_rsp_data = '0;
  logic        mc_rsp_stall;
  logic        busy, err_overflow;

  always #5 clk = ~clk;

  spmv_mc_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
    .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_req_stall(mc_req_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
    .mc_rsp_stall(mc_rsp_stall), .busy(busy), .err_overflow(err_overflow)
  );

  typedef struct packed { logic ld; logic st; logic [47:0] addr; logic [63:0] wrd; } mc_req_t;
  typedef struct packed { logic [2:0] tag; logic [63:0] data; } rsp_t;

  mc_req_t    req_sb[$];
  rsp_t       rsp_sb[$];
  logic [2:0] mc_pend[$];
  int n_cmp = 0, n_fail = 0;
  int ld_fires = 0, st_fires = 0, rsp_pops = 0;
  mc_req_t mon_got, mon_exp;
  rsp_t    mon_rgot, mon_rexp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ld_dt(input logic [2:0] tag);
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a, b[31:3], tag};
  endfunction

  task automatic pe_req(input logic st, input logic [47:0] addr, input logic [63:0] dt, input bit acc);
    mc_req_t e;
    req_mem_ld = !st;
    req_mem_st = st;
    req_mem_addr = addr;
    req_mem_d_or_tag = dt;
    e.ld = !st;
    e.st = st;
    e.addr = addr;
    e.wrd = st ? dt : {61'b0, dt[2:0]};
    if (acc) req_sb.push_back(e);
    tick();
    req_mem_ld = 1'b0;
    req_mem_st = 1'b0;
  endtask

  task automatic respond(input logic [63:0] data);
    logic [31:0] r;
    rsp_t e;
    r = $urandom;
    e.tag = mc_pend.pop_front();
    e.data = data;
    mc_rsp_push = 1'b1;
    mc_rsp_rdctl = {r[31:3], e.tag};
    mc_rsp_data = data;
    rsp_sb.push_back(e);
    tick();
    mc_rsp_push = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      done = (req_sb.size() == 0) && (rsp_sb.size() == 0) && (mc_pend.size() == 0) && (busy === 1'b0);
      if (done) break;
      if (mc_pend.size() > 0) respond({$urandom, $urandom});
      else tick();
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_stall"}, req_mem_stall, 1'b0);
    chk({tag, "_rsp_push"}, rsp_mem_push, 1'b0);
    chk({tag, "_rsp_tag"}, rsp_mem_tag, 3'd0);
    chk({tag, "_rsp_q"}, rsp_mem_q, 64'd0);
    chk({tag, "_mc_ld"}, mc_req_ld, 1'b0);
    chk({tag, "_mc_st"}, mc_req_st, 1'b0);
    chk({tag, "_vadr"}, mc_req_vadr, 48'd0);
    chk({tag, "_wrd"}, mc_req_wrd_rdctl, 64'd0);
    chk({tag, "_mc_rsp_stall"}, mc_rsp_stall, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err_overflow, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int base, base_st, pushed;

    // Monitor: pops the scoreboards whenever the DUT issues to the MC or returns to the PE.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (mc_req_ld || mc_req_st) begin
            mon_got.ld = mc_req_ld;
            mon_got.st = mc_req_st;
            mon_got.addr = mc_req_vadr;
            mon_got.wrd = mc_req_wrd_rdctl;
            if (req_sb.size() == 0) chk("unexpected_mc_req", mon_got, 0);
            else begin
              mon_exp = req_sb.pop_front();
              chk("mc_req", mon_got, mon_exp);
            end
            if (mc_req_ld) begin
              ld_fires++;
              mc_pend.push_back(mc_req_wrd_rdctl[2:0]);
            end
            if (mc_req_st) st_fires++;
          end
          if (rsp_mem_push) begin
            rsp_pops++;
            mon_rgot.tag = rsp_mem_tag;
            mon_rgot.data = rsp_mem_q;
            if (rsp_sb.size() == 0) chk("unexpected_rsp", mon_rgot, 0);
            else begin
              mon_rexp = rsp_sb.pop_front();
              chk("rsp_order", mon_rgot, mon_rexp);
            end
          end
          if (ld_fires - rsp_pops > 32) chk("credit_bound", ld_fires - rsp_pops, 32);
        end
      end
    join_none

    // Reset state
    tick(); tick(); tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // T1: single load, MC returns 0xDEAD after 10 cycles
    pe_req(1'b0, 48'h1000, ld_dt(3'd5), 1'b1);
    chk("t1_fire", mc_req_ld, 1'b1);
    chk("t1_vadr", mc_req_vadr, 48'h1000);
    chk("t1_rdctl", mc_req_wrd_rdctl, 64'd5);
    tick();
    chk("t1_one_cycle", mc_req_ld, 1'b0);
    chk("t1_busy", busy, 1'b1);
    repeat (9) tick();
    respond(64'hDEAD);
    chk("t1_rsp_lat1", rsp_mem_push, 1'b0);
    tick();
    chk("t1_rsp_push", rsp_mem_push, 1'b1);
    chk("t1_rsp_tag", rsp_mem_tag, 3'd5);
    chk("t1_rsp_q", rsp_mem_q, 64'hDEAD);
    tick();
    chk("t1_rsp_once", rsp_mem_push, 1'b0);
    chk("t1_busy_fall", busy, 1'b0);
    drain("t1_drain");

    // T2: loads until stalled, MC silent -> 32 fire, then one per response
    base = ld_fires;
    pushed = 0;
    while (pushed < 80 && !req_mem_stall) begin
      pe_req(1'b0, 48'h4000 + 48'(pushed * 8), ld_dt(3'(pushed)), 1'b1);
      pushed++;
    end
    repeat (5) tick();
    chk("t2_fired", ld_fires - base, 32);
    chk("t2_stall", req_mem_stall, 1'b1);
    chk("t2_ld_low", mc_req_ld, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      respond({$urandom, $urandom});
      repeat (5) tick();
      chk("t2_one_more", ld_fires - base, 32 + k);
    end
    drain("t2_drain");

    // T3: MC stalled for 50 cycles during a mixed burst
    base = ld_fires + st_fires;
    mc_req_stall = 1'b1;
    pushed = 0;
    while (pushed < 40 && !req_mem_stall) begin
      pe_req(pushed % 3 == 2, 48'h8000 + 48'(pushed * 8),
             (pushed % 3 == 2) ? {$urandom, $urandom} : ld_dt(3'(pushed)), 1'b1);
      pushed++;
    end
    chk("t3_pushed", pushed, 29);
    for (int i = pushed; i < 50; i++) tick();
    chk("t3_stall", req_mem_stall, 1'b1);
    chk("t3_no_fire", ld_fires + st_fires - base, 0);
    chk("t3_no_err", err_overflow, 1'b0);
    mc_req_stall = 1'b0;
    drain("t3_drain");
    chk("t3_no_err_end", err_overflow, 1'b0);

    // T4: store behind a credit-blocked load
    base = ld_fires;
    base_st = st_fires;
    for (int i = 0; i < 33; i++) pe_req(1'b0, 48'hC000 + 48'(i * 8), ld_dt(3'(i)), 1'b1);
    pe_req(1'b1, 48'h2000, 64'h55, 1'b1);
    repeat (8) tick();
    chk("t4_ld_held", ld_fires - base, 32);
    chk("t4_st_held", st_fires - base_st, 0);
    chk("t4_st_low", mc_req_st, 1'b0);
    respond({$urandom, $urandom});
    repeat (6) tick();
    chk("t4_ld_released", ld_fires - base, 33);
    chk("t4_st_released", st_fires - base_st, 1);
    drain("t4_drain");

    // T5: PE stalls responses for 20 cycles while 8 arrive
    rsp_mem_stall = 1'b1;
    for (int i = 0; i < 8; i++) pe_req(1'b0, 48'hE000 + 48'(i * 8), ld_dt(3'(7 - i)), 1'b1);
    tick(); tick();
    chk("t5_pending", mc_pend.size(), 8);
    for (int i = 0; i < 8; i++) respond({$urandom, $urandom});
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_held", rsp_mem_push, 1'b0);
    end
    chk("t5_busy", busy, 1'b1);
    rsp_mem_stall = 1'b0;
    drain("t5_drain");

    // T6: overflow, then asynchronous reset mid-burst
    mc_req_stall = 1'b1;
    for (int i = 0; i < 32; i++) pe_req(1'b0, 48'h10000 + 48'(i * 8), ld_dt(3'(i)), 1'b1);
    chk("t6_err_before", err_overflow, 1'b0);
    pe_req(1'b0, 48'h1F000, ld_dt(3'd1), 1'b0);
    chk("t6_err_set", err_overflow, 1'b1);
    mc_req_stall = 1'b0;
    tick(); tick(); tick();
    chk("t6_burst_live", mc_req_ld, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_async");
    req_sb.delete();
    rsp_sb.delete();
    mc_pend.delete();
    ld_fires = 0;
    rsp_pops = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("t6_after");
    pe_req(1'b0, 48'h3000, ld_dt(3'd2), 1'b1);
    drain("t6_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
